// File: rtl/bht_controller.sv
// Branch history table: 2-bit saturating counters, one table access per cycle, with
// resolved-branch updates buffered in a 2-entry in-order FIFO.
module bht_controller #(
   parameter int unsigned IDX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   // Fetch-stage lookup
   input  logic        lkp_valid,
   input  logic [31:0] lkp_pc,
   output logic        lkp_ready,
   output logic        pred_valid,
   output logic        pred_taken,
   // Execute-stage update
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic        upd_pred,
   output logic        upd_ready,
   output logic [15:0] mispredict_count
);

   localparam int unsigned DEPTH     = 2 ** IDX_BITS;
   localparam int unsigned FIFO_SIZE = 2;

   typedef enum logic [1:0] {
      SlotIdle,
      SlotLookup,
      SlotDrain
   } slot_e;

   // Counter table
   logic [1:0]          table_q [DEPTH];

   // Update FIFO; entry 0 is always the head
   logic [IDX_BITS-1:0] fifo_idx_q [FIFO_SIZE];
   logic [IDX_BITS-1:0] fifo_idx_d [FIFO_SIZE];
   logic                fifo_tkn_q [FIFO_SIZE];
   logic                fifo_tkn_d [FIFO_SIZE];
   logic [1:0]          fifo_cnt_q;
   logic [1:0]          fifo_cnt_d;
   logic                fifo_full;
   logic                fifo_empty;

   // Prediction and statistics state
   logic                pred_valid_q;
   logic                pred_taken_q;
   logic [15:0]         mis_cnt_q;
   logic [15:0]         mis_cnt_d;

   // Slot arbitration and handshakes
   slot_e               slot;
   logic                lkp_fire;
   logic                upd_fire;
   logic                drain_fire;

   logic [IDX_BITS-1:0] lkp_idx;
   logic [IDX_BITS-1:0] upd_idx;
   logic [IDX_BITS-1:0] drain_idx;
   logic                drain_tkn;
   logic [1:0]          drain_ctr_next;

   logic                unused_pc_bits;

   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != 2'b11) res = ctr + 2'd1;
      end else begin
         if (ctr != 2'b00) res = ctr - 2'd1;
      end
      return res;
   endfunction

   assign lkp_idx   = lkp_pc[IDX_BITS+1:2];
   assign upd_idx   = upd_pc[IDX_BITS+1:2];
   assign drain_idx = fifo_idx_q[0];
   assign drain_tkn = fifo_tkn_q[0];

   assign unused_pc_bits = ^{lkp_pc[31:IDX_BITS+2], lkp_pc[1:0],
                             upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

   assign fifo_full  = (fifo_cnt_q == 2'd2);
   assign fifo_empty = (fifo_cnt_q == 2'd0);

   assign lkp_ready = !fifo_full;
   assign upd_ready = !fifo_full;

   // A full FIFO takes the slot so that update acceptance can resume next cycle
   always_comb begin
      slot = SlotIdle;
      if (fifo_full) begin
         slot = SlotDrain;
      end else if (lkp_valid) begin
         slot = SlotLookup;
      end else if (!fifo_empty) begin
         slot = SlotDrain;
      end
   end

   assign lkp_fire   = (slot == SlotLookup);
   assign drain_fire = (slot == SlotDrain);
   assign upd_fire   = upd_valid && upd_ready;

   assign drain_ctr_next = ctr_step(table_q[drain_idx], drain_tkn);

   // FIFO next state; a simultaneous enqueue and drain only happens at occupancy 1
   always_comb begin
      fifo_idx_d = fifo_idx_q;
      fifo_tkn_d = fifo_tkn_q;
      fifo_cnt_d = fifo_cnt_q;
      unique case ({upd_fire, drain_fire})
         2'b10: begin
            fifo_idx_d[fifo_cnt_q[0]] = upd_idx;
            fifo_tkn_d[fifo_cnt_q[0]] = upd_taken;
            fifo_cnt_d                = fifo_cnt_q + 2'd1;
         end
         2'b01: begin
            fifo_idx_d[0] = fifo_idx_q[1];
            fifo_tkn_d[0] = fifo_tkn_q[1];
            fifo_cnt_d    = fifo_cnt_q - 2'd1;
         end
         2'b11: begin
            fifo_idx_d[0] = upd_idx;
            fifo_tkn_d[0] = upd_taken;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      mis_cnt_d = mis_cnt_q;
      if (upd_fire && (upd_pred != upd_taken) && (mis_cnt_q != 16'hFFFF)) begin
         mis_cnt_d = mis_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            table_q[i] <= 2'b01;
         end
      end else if (drain_fire) begin
         table_q[drain_idx] <= drain_ctr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < FIFO_SIZE; i++) begin
            fifo_idx_q[i] <= '0;
            fifo_tkn_q[i] <= 1'b0;
         end
         fifo_cnt_q <= 2'd0;
      end else begin
         fifo_idx_q <= fifo_idx_d;
         fifo_tkn_q <= fifo_tkn_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         mis_cnt_q    <= 16'd0;
      end else begin
         pred_valid_q <= lkp_fire;
         if (lkp_fire) begin
            pred_taken_q <= table_q[lkp_idx][1];
         end
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign pred_valid       = pred_valid_q;
   assign pred_taken       = pred_taken_q;
   assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_bht_controller.sv
// Directed bench for bht_controller: hand-computed predictions, handshakes and
// mispredict counts across saturation, backpressure, no-bypass and reset scenarios.
module tb_bht_controller;

   logic        clk;
   logic        reset;
   logic        lkp_valid;
   logic [31:0] lkp_pc;
   logic        lkp_ready;
   logic        pred_valid;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        upd_pred;
   logic        upd_ready;
   logic [15:0] mispredict_count;

   int checks;
   int failures;

   bht_controller #(.IDX_BITS(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .lkp_valid        (lkp_valid),
      .lkp_pc           (lkp_pc),
      .lkp_ready        (lkp_ready),
      .pred_valid       (pred_valid),
      .pred_taken       (pred_taken),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_pred         (upd_pred),
      .upd_ready        (upd_ready),
      .mispredict_count (mispredict_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken);
      lkp_valid = 1'b1;
      lkp_pc    = pc;
      step();
      lkp_valid = 1'b0;
      check({tag, "_pv"}, {31'd0, pred_valid}, 32'd1);
      check({tag, "_pt"}, {31'd0, pred_taken}, {31'd0, exp_taken});
   endtask

   task automatic set_upd(input logic v, input logic [31:0] pc, input logic t, input logic p);
      upd_valid = v;
      upd_pc    = pc;
      upd_taken = t;
      upd_pred  = p;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      lkp_valid = 1'b0;
      lkp_pc    = 32'd0;
      set_upd(1'b0, 32'd0, 1'b0, 1'b0);

      // Reset state
      step();
      step();
      check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rst_mis_count", {16'd0, mispredict_count}, 32'd0);
      reset = 1'b0;
      step();
      check("post_rst_lkp_ready", {31'd0, lkp_ready}, 32'd1);
      check("post_rst_upd_ready", {31'd0, upd_ready}, 32'd1);

      // Fresh counter 01 predicts not taken; pred_valid is a one-cycle pulse
      lookup("lkp40_init", 32'h40, 1'b0);
      step();
      check("idle_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("idle_pred_hold", {31'd0, pred_taken}, 32'd0);

      // Two taken mispredicted updates: 01 -> 10 -> 11
      set_upd(1'b1, 32'h40, 1'b1, 1'b0);
      step();
      check("mis_after_one", {16'd0, mispredict_count}, 32'd1);
      step();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0);
      check("mis_after_two", {16'd0, mispredict_count}, 32'd2);
      step();
      lookup("lkp40_strong", 32'h40, 1'b1);
      step();
      check("hold_taken", {31'd0, pred_taken}, 32'd1);

      // Saturation at 11, then two not-taken steps down to 01
      set_upd(1'b1, 32'h40, 1'b1, 1'b1);
      step();
      step();
      step();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      lookup("lkp40_sat", 32'h40, 1'b1);
      check("mis_sat_taken", {16'd0, mispredict_count}, 32'd2);
      set_upd(1'b1, 32'h40, 1'b0, 1'b1);
      step();
      step();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      lookup("lkp40_down", 32'h40, 1'b0);
      check("mis_not_taken", {16'd0, mispredict_count}, 32'd4);

      // Backpressure: lookups every cycle while three updates arrive
      lkp_valid = 1'b1;
      lkp_pc    = 32'h50;
      set_upd(1'b1, 32'h48, 1'b1, 1'b0);
      step();
      check("bp_a_upd_ready", {31'd0, upd_ready}, 32'd1);
      check("bp_a_pred_valid", {31'd0, pred_valid}, 32'd1);
      step();
      check("bp_b_lkp_ready", {31'd0, lkp_ready}, 32'd0);
      check("bp_b_upd_ready", {31'd0, upd_ready}, 32'd0);
      check("bp_b_pred_valid", {31'd0, pred_valid}, 32'd1);
      step();
      check("bp_c_lkp_ready", {31'd0, lkp_ready}, 32'd1);
      check("bp_c_upd_ready", {31'd0, upd_ready}, 32'd1);
      check("bp_c_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("bp_c_mis_stall", {16'd0, mispredict_count}, 32'd6);
      step();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0);
      lkp_valid = 1'b0;
      check("bp_d_upd_ready", {31'd0, upd_ready}, 32'd0);
      check("bp_d_pred_valid", {31'd0, pred_valid}, 32'd1);
      check("bp_d_mis", {16'd0, mispredict_count}, 32'd7);
      step();
      step();
      lookup("lkp48_after_bp", 32'h48, 1'b1);
      lookup("lkp50_untouched", 32'h50, 1'b0);

      // Same-cycle update and lookup of one index: lookup sees the old counter
      lkp_valid = 1'b1;
      lkp_pc    = 32'h44;
      set_upd(1'b1, 32'h44, 1'b1, 1'b1);
      step();
      lkp_valid = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 1'b0);
      check("nobypass_pv", {31'd0, pred_valid}, 32'd1);
      check("nobypass_pt", {31'd0, pred_taken}, 32'd0);
      step();
      lookup("lkp44_drained", 32'h44, 1'b1);
      check("mis_nobypass", {16'd0, mispredict_count}, 32'd7);

      // Fill the FIFO, then reset with a lookup offered during the reset cycle
      lkp_valid = 1'b1;
      lkp_pc    = 32'h60;
      set_upd(1'b1, 32'h4C, 1'b1, 1'b0);
      step();
      step();
      check("prerst_full", {31'd0, upd_ready}, 32'd0);
      check("prerst_mis", {16'd0, mispredict_count}, 32'd9);
      set_upd(1'b0, 32'h0, 1'b0, 1'b0);
      reset  = 1'b1;
      lkp_pc = 32'h48;
      step();
      check("rst2_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst2_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rst2_mis", {16'd0, mispredict_count}, 32'd0);
      reset     = 1'b0;
      lkp_valid = 1'b0;
      step();
      check("rst2_lkp_ready", {31'd0, lkp_ready}, 32'd1);
      check("rst2_upd_ready", {31'd0, upd_ready}, 32'd1);
      step();
      step();
      lookup("rst2_lkp4c", 32'h4C, 1'b0);
      lookup("rst2_lkp48", 32'h48, 1'b0);
      lookup("rst2_lkp44", 32'h44, 1'b0);
      lookup("rst2_lkp40", 32'h40, 1'b0);
      check("rst2_mis_end", {16'd0, mispredict_count}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bht_controller.md
BHT_CONTROLLER -- requirements
Module: bht_controller

Interface
REQ-001 Parameter IDX_BITS, default 4, SHALL set table depth to 2**IDX_BITS entries of 2-bit counters, indexed by pc[IDX_BITS+1:2].
REQ-002 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 lkp_valid  input  1  SHALL indicate a fetch-stage prediction request.
REQ-005 lkp_pc  input  32  SHALL be the PC of the lookup.
REQ-006 lkp_ready  output  1  SHALL indicate the lookup is accepted this cycle.
REQ-007 pred_valid  output  1  SHALL indicate pred_taken is valid.
REQ-008 pred_taken  output  1  SHALL be the prediction: 1 = take, 0 = no take.
REQ-009 upd_valid  input  1  SHALL indicate an execute-stage resolved-branch update.
REQ-010 upd_pc  input  32  SHALL be the PC of the resolved branch.
REQ-011 upd_taken  input  1  SHALL be the actual branch outcome.
REQ-012 upd_pred  input  1  SHALL be the prediction originally used for that branch.
REQ-013 upd_ready  output  1  SHALL indicate the update is accepted this cycle.
REQ-014 mispredict_count  output  16  SHALL be the count of accepted updates with upd_pred != upd_taken.

Function
REQ-015 Table SHALL have one access slot per cycle: either one lookup read or one update read-modify-write, never both.
REQ-016 Accepted updates SHALL enter a 2-entry in-order FIFO (index, outcome); the FIFO drains into the table one entry per granted slot.
REQ-017 lkp_ready and upd_ready SHALL both equal !fifo_full, combinationally.
REQ-018 Arbitration: FIFO full -> drain wins the slot and the lookup stalls; otherwise lkp_valid wins; otherwise a non-empty FIFO drains.
REQ-019 Lookup handshake: lkp_valid && lkp_ready at edge N -> pred_valid = 1 during cycle N+1, with pred_taken = bit[1] of the indexed counter as it was at edge N.
REQ-020 pred_valid SHALL be 0 in any cycle not following an accepted lookup; pred_taken SHALL hold its last value when pred_valid = 0.
REQ-021 Counter update on drain: outcome taken -> counter+1, saturating at 2'b11; not taken -> counter-1, saturating at 2'b00.
REQ-022 Counter encoding SHALL be 00 strongly not taken, 01 not taken, 10 taken, 11 strongly taken.
REQ-023 Enqueue and drain in the same cycle SHALL be legal when the FIFO is not full; occupancy stays unchanged.
REQ-024 Lookups SHALL NOT bypass the FIFO: a lookup to an index with a queued update returns the pre-update counter.
REQ-025 Two queued updates to the same index SHALL apply sequentially; the second operates on the result of the first.
REQ-026 mispredict_count SHALL increment at enqueue when upd_pred != upd_taken, saturating at 16'hFFFF.
REQ-027 Updates offered while upd_ready = 0 SHALL NOT be counted and SHALL NOT modify state.

Reset
REQ-028 On reset, all counters SHALL be set to 01 and the FIFO emptied, discarding any pending updates.
REQ-029 On reset, pred_valid, pred_taken and mispredict_count SHALL be 0.
REQ-030 On reset, handshakes presented in the reset cycle SHALL be ignored.
REQ-031 The cycle after reset deasserts, lkp_ready and upd_ready SHALL be 1.

Verification
REQ-032 Reset, then lookup pc=0x40 -> next cycle pred_valid=1, pred_taken=0.
REQ-033 Two taken updates for pc=0x40 (upd_pred=0), no lookups, then lookup 0x40 -> pred_taken=1 (counter 11), mispredict_count=2.
REQ-034 Counter at 11, then three taken updates -> counter stays 11; then two not-taken updates -> counter 01, lookup gives 0.
REQ-035 Continuous lkp_valid with 3 back-to-back updates -> FIFO fills after 2, both readies drop for one cycle, one drain occurs, third update accepted when ready returns.
REQ-036 Update enqueued for pc=0x44 and same-cycle lookup of 0x44 with counter at 01 -> pred_taken=0 (no bypass); after drain, lookup gives 1.
REQ-037 Reset asserted with 2 queued updates -> afterwards all lookups predict 0, mispredict_count=0, no stale drain.
